matrix_scan_driver: RTL and testbench

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_scan_driver_pkg.sv | 24 ++
 rtl/matrix_scan_driver_scan_timer.sv | 53 +++++
 rtl/matrix_scan_driver.sv | 118 +++++++++++
 tb/tb_matrix_scan_driver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_driver_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// matrix_scan_driver_pkg: shared defaults and width helper for the scanner
// Rev 1.0
// ------------------------------------------------------------------
package matrix_scan_driver_pkg;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_COLS     = 16;
  localparam int DEF_BLANK    = 2;
  localparam int DEF_BRIGHT_W = 4;

  // Minimum of one bit so a counter over a single state still has a width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_driver_scan_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// scan_timer: row-phase and row counters with frame start/end strobes
// Rev 1.0
// ------------------------------------------------------------------
module scan_timer
  import matrix_scan_driver_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int PERIOD = DEF_BLANK + (2 ** DEF_BRIGHT_W),
  parameter int ROW_W  = clog2(ROWS),
  parameter int PH_W   = clog2(PERIOD)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [PH_W-1:0]  ph,
  output logic [ROW_W-1:0] row,
  output logic             frame_end,
  output logic             frame_start
);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [PH_W-1:0]  ph_q,  ph_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    ph_d  = ph_q + PH_W'(1);
    row_d = row_q;
    if (ph_q == PH_LAST) begin
      ph_d  = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ph_q  <= '0;
      row_q <= '0;
    end else begin
      ph_q  <= ph_d;
      row_q <= row_d;
    end
  end

  assign ph          = ph_q;
  assign row         = row_q;
  assign frame_end   = (row_q == ROW_LAST) && (ph_q == PH_LAST);
  assign frame_start = (row_q == '0) && (ph_q == '0);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ------------------------------------------------------------------
// matrix_scan_driver: double-buffered LED matrix row scanner with PWM brightness
// Rev 1.0
// ------------------------------------------------------------------
module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int BLANK    = DEF_BLANK,
  parameter int BRIGHT_W = DEF_BRIGHT_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     swap_req,
  input  logic [BRIGHT_W-1:0]      brightness,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_out,
  output logic                     swap_pending,
  output logic                     frame_start
);

  localparam int ROW_W  = clog2(ROWS);
  localparam int PERIOD = BLANK + (2 ** BRIGHT_W);
  localparam int PH_W   = clog2(PERIOD);

  logic [PH_W-1:0]  ph;
  logic [ROW_W-1:0] row;
  logic             frame_end;
  logic             timer_frame_start;

  scan_timer #(
    .ROWS   (ROWS),
    .PERIOD (PERIOD),
    .ROW_W  (ROW_W),
    .PH_W   (PH_W)
  ) u_scan_timer (
    .clock       (clock),
    .reset_n     (reset_n),
    .ph          (ph),
    .row         (row),
    .frame_end   (frame_end),
    .frame_start (timer_frame_start)
  );

  logic [COLS-1:0]     buf_q [2][ROWS];
  logic [COLS-1:0]     buf_d [2][ROWS];
  logic                front_q, front_d;
  logic                swap_pending_q, swap_pending_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [ROWS-1:0]     row_sel_q, row_sel_d;
  logic [COLS-1:0]     col_out_q, col_out_d;
  logic                frame_start_q, frame_start_d;
  logic                swap_now;

  // Writes always go to whichever buffer is back this cycle, even on the swap edge.
  always_comb begin
    buf_d = buf_q;
    if (wr_en && (32'(wr_row) < ROWS)) begin
      buf_d[~front_q][wr_row] = wr_data;
    end
  end

  // A request on the final cycle both lets the pending swap complete and re-arms.
  always_comb begin
    swap_now       = frame_end && swap_pending_q;
    front_d        = front_q ^ swap_now;
    swap_pending_d = swap_req | (swap_pending_q & ~swap_now);
    bright_d       = timer_frame_start ? brightness : bright_q;
  end

  always_comb begin
    row_sel_d     = '0;
    col_out_d     = '1;
    frame_start_d = timer_frame_start;
    if (32'(ph) >= BLANK) begin
      row_sel_d[row] = 1'b1;
      if ((32'(ph) - BLANK) < 32'(bright_q)) begin
        col_out_d = ~buf_q[front_q][row];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          buf_q[b][r] <= '0;
        end
      end
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      bright_q       <= '0;
      row_sel_q      <= '0;
      col_out_q      <= '1;
      frame_start_q  <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      bright_q       <= bright_d;
      row_sel_q      <= row_sel_d;
      col_out_q      <= col_out_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign row_sel      = row_sel_q;
  assign col_out      = col_out_q;
  assign swap_pending = swap_pending_q;
  assign frame_start  = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_matrix_scan_driver: frame-level scoreboard bench for the scanner
// Rev 1.0
// ------------------------------------------------------------------
module tb_matrix_scan_driver;

  localparam int ROWS     = 4;
  localparam int COLS     = 8;
  localparam int BLANK    = 2;
  localparam int BRIGHT_W = 2;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b1;
  logic       wr_en      = 1'b0;
  logic [1:0] wr_row     = '0;
  logic [7:0] wr_data    = '0;
  logic       swap_req   = 1'b0;
  logic [1:0] brightness = '0;
  logic [3:0] row_sel;
  logic [7:0] col_out;
  logic       swap_pending;
  logic       frame_start;

  int total  = 0;
  int bad    = 0;
  int fcount = 0;

  typedef struct packed {
    int              tag;
    logic [3:0][7:0] pix;
    logic [3:0][2:0] lit;
    logic            sp_first;
    logic            sp_end;
  } exp_t;

  exp_t sb_q[$];

  matrix_scan_driver #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .BLANK    (BLANK),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .brightness   (brightness),
    .row_sel      (row_sel),
    .col_out      (col_out),
    .swap_pending (swap_pending),
    .frame_start  (frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int tag, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3, input int l,
                              input logic sf, input logic se);
    exp_t e;
    e.tag = tag;
    e.pix[0] = p0; e.pix[1] = p1; e.pix[2] = p2; e.pix[3] = p3;
    for (int r = 0; r < 4; r++) e.lit[r] = 3'(l);
    e.sp_first = sf;
    e.sp_end   = se;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_row(input logic [1:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  // Returns at the start of the third cycle (index 2) of the newly started frame.
  task automatic wait_frame(output int n);
    int start;
    start = fcount;
    for (int i = 0; i < 60 && fcount == start; i++) @(posedge clock);
    if (fcount == start) begin
      total++; bad++;
      $display("FAIL wait_frame: got no frame_start want one within 60 cycles");
    end
    n = fcount;
    #1;
  endtask

  // Monitor: capture each 24-cycle frame and compare it with the queued expectation.
  initial begin : monitor
    time             last_t;
    bit              have_last;
    logic [3:0][7:0] pix;
    logic [3:0][2:0] lit;
    logic            sp_first, sp_end;
    logic [3:0]      ers;
    int              seq_err, slot, r;
    bit              aborted;
    exp_t            e;
    have_last = 0;
    last_t    = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        have_last = 0;
      end else if (frame_start) begin
        fcount++;
        if (have_last) chk($sformatf("f%0d_period", fcount), 64'($time - last_t), 64'd240);
        last_t = $time; have_last = 1;
        pix = '1; lit = '0; seq_err = 0; aborted = 0;
        sp_first = swap_pending; sp_end = 1'b0;
        for (int k = 0; k < 24; k++) begin
          if (k > 0) @(negedge clock);
          if (!reset_n) begin
            aborted = 1; have_last = 0;
            break;
          end
          slot = k % 6;
          r    = k / 6;
          ers  = '0;
          if (slot >= 2) ers[r] = 1'b1;
          if (row_sel !== ers) seq_err++;
          if (k > 0 && frame_start !== 1'b0) seq_err++;
          if (slot < 2) begin
            if (col_out !== 8'hFF) seq_err++;
          end else if (col_out !== 8'hFF) begin
            if ((slot - 2) != int'(lit[r])) seq_err++;
            lit[r] = lit[r] + 3'd1;
            pix[r] = col_out;
          end
          if (k == 22) sp_end = swap_pending;
        end
        if (!aborted) begin
          while (sb_q.size() > 0 && sb_q[0].tag < fcount) begin
            total++; bad++;
            $display("FAIL f%0d_missing: got no captured frame want frame %0d", fcount, sb_q[0].tag);
            void'(sb_q.pop_front());
          end
          if (sb_q.size() > 0 && sb_q[0].tag == fcount) begin
            e = sb_q.pop_front();
            chk($sformatf("f%0d_seq", fcount), 64'(seq_err), 64'd0);
            chk($sformatf("f%0d_pix", fcount), 64'(pix), 64'(e.pix));
            chk($sformatf("f%0d_lit", fcount), 64'(lit), 64'(e.lit));
            chk($sformatf("f%0d_sp_first", fcount), 64'(sp_first), 64'(e.sp_first));
            chk($sformatf("f%0d_sp_end", fcount), 64'(sp_end), 64'(e.sp_end));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    total++; bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    int n;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_row_sel", 64'(row_sel), 64'h0);
    chk("rst_col_out", 64'(col_out), 64'hFF);
    chk("rst_swap_pending", 64'(swap_pending), 64'h0);
    chk("rst_frame_start", 64'(frame_start), 64'h0);
    #20 reset_n = 1'b1;

    // Frame A: blank display, load back buffer with 0x81 and request a swap.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b1));
    brightness = 2'd3;
    for (int r = 0; r < 4; r++) write_row(2'(r), 8'h81);
    pulse_swap();

    // 0x81 shown at full brightness; mid-frame brightness change must not apply yet.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 3, 1'b0, 1'b0));
    brightness = 2'd1;
    write_row(2'd0, 8'h01);
    write_row(2'd1, 8'h02);
    write_row(2'd2, 8'h04);
    write_row(2'd3, 8'hF0);
    wr_row = 2'd0; wr_data = 8'hFF;
    tick();

    // Two requests in one frame give one swap.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 1, 1'b0, 1'b1));
    brightness = 2'd2;
    pulse_swap();
    repeat (3) tick();
    pulse_swap();

    // Request in the final cycle while already pending: swap now and stay pending.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFE, 8'hFD, 8'hFB, 8'h0F, 2, 1'b0, 1'b1));
    pulse_swap();
    repeat (20) tick();
    pulse_swap();

    // Second swap one frame later; a write on the swap cycle lands in the new front.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 2, 1'b1, 1'b1));
    repeat (21) tick();
    write_row(2'd3, 8'h3C);

    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFE, 8'hFD, 8'hFB, 8'hC3, 2, 1'b0, 1'b0));
    brightness = 2'd0;

    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b0));
    brightness = 2'd3;

    // Mid-row reset with a swap pending: outputs drop without a clock edge.
    wait_frame(n);
    pulse_swap();
    repeat (4) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_row_sel", 64'(row_sel), 64'h0);
    chk("midrst_col_out", 64'(col_out), 64'hFF);
    chk("midrst_swap_pending", 64'(swap_pending), 64'h0);
    chk("midrst_frame_start", 64'(frame_start), 64'h0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Both buffers must be cleared: front A then, after a swap, front B.
    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b1));
    pulse_swap();

    wait_frame(n);
    sb_q.push_back(mk(n, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b0));

    wait_frame(n);
    repeat (3) tick();
    while (sb_q.size() > 0) begin
      total++; bad++;
      $display("FAIL leftover: got unchecked frame %0d want none", sb_q[0].tag);
      void'(sb_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
